// File: rtl/lock_ctrl_if.sv
// Door-lock controller signal bundle.
// Master drives sensor/code inputs; slave is the controller.
interface lock_ctrl_if;
    logic       unlock;
    logic       door_open;
    logic       latch_release;
    logic       door_alarm;
    logic       busy;
    logic [7:0] entry_count;

    modport master (
        output unlock,
        output door_open,
        input  latch_release,
        input  door_alarm,
        input  busy,
        input  entry_count
    );

    modport slave (
        input  unlock,
        input  door_open,
        output latch_release,
        output door_alarm,
        output busy,
        output entry_count
    );
endinterface

// File: rtl/lock_ctrl.sv
// Door-lock FSM: timed latch release, ajar/forced alarm,
// one-cycle relock and a saturating entry counter.
module lock_ctrl #(
    parameter int OPEN_CYCLES = 16,
    parameter int AJAR_LIMIT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    lock_ctrl_if.slave  bus
);
    localparam int OW = $clog2(OPEN_CYCLES);
    localparam int AW = $clog2(AJAR_LIMIT);
    localparam logic [OW-1:0] OPEN_LAST = OW'(OPEN_CYCLES - 1);
    localparam logic [AW-1:0] AJAR_LAST = AW'(AJAR_LIMIT - 1);

    typedef enum logic [2:0] {
        LOCKED  = 3'd0,
        RELEASE = 3'd1,
        OPENED  = 3'd2,
        ALARM   = 3'd3,
        RELOCK  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          unlock_q;
    logic          unlock_edge;
    logic [OW-1:0] open_cnt;
    logic [AW-1:0] ajar_cnt;
    logic          latch_r;
    logic          alarm_r;
    logic          busy_r;
    logic [7:0]    entry_r;

    assign unlock_edge = bus.unlock & ~unlock_q;

    // Door sensor beats the code in LOCKED: an open door there is forced.
    always_comb begin
        state_n = state;
        case (state)
            LOCKED: begin
                if (bus.door_open)
                    state_n = ALARM;
                else if (unlock_edge)
                    state_n = RELEASE;
            end
            RELEASE: begin
                if (bus.door_open)
                    state_n = OPENED;
                else if (open_cnt == OPEN_LAST)
                    state_n = LOCKED;
            end
            OPENED: begin
                if (!bus.door_open)
                    state_n = RELOCK;
                else if (ajar_cnt == AJAR_LAST)
                    state_n = ALARM;
            end
            ALARM: begin
                if (!bus.door_open)
                    state_n = RELOCK;
            end
            RELOCK:  state_n = LOCKED;
            default: state_n = LOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOCKED;
            unlock_q <= 1'b0;
            open_cnt <= '0;
            ajar_cnt <= '0;
            entry_r  <= 8'd0;
            latch_r  <= 1'b0;
            alarm_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state    <= state_n;
            unlock_q <= bus.unlock;
            // Counters restart whenever their state is (re)entered.
            if (state == RELEASE && state_n == RELEASE)
                open_cnt <= open_cnt + 1'b1;
            else
                open_cnt <= '0;
            if (state == OPENED && state_n == OPENED)
                ajar_cnt <= ajar_cnt + 1'b1;
            else
                ajar_cnt <= '0;
            if (state == RELEASE && state_n == OPENED &&
                entry_r != 8'hff)
                entry_r <= entry_r + 8'd1;
            latch_r <= (state_n == RELEASE);
            alarm_r <= (state_n == ALARM);
            busy_r  <= (state_n != LOCKED);
        end
    end

    assign bus.latch_release = latch_r;
    assign bus.door_alarm    = alarm_r;
    assign bus.busy          = busy_r;
    assign bus.entry_count   = entry_r;
endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl (OPEN_CYCLES=4, AJAR_LIMIT=8):
// vector table plus hand sequences for multi-cycle corners.
module tb_lock_ctrl;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    lock_ctrl_if bus ();

    lock_ctrl #(
        .OPEN_CYCLES(4),
        .AJAR_LIMIT (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       unl;
        logic       door;
        logic       lr;
        logic       al;
        logic       bsy;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic u, logic d,
                                logic lr, logic al, logic b,
                                logic [7:0] c);
        vec_t v;
        v.rst = r; v.unl = u; v.door = d;
        v.lr = lr; v.al = al; v.bsy = b; v.cnt = c;
        return v;
    endfunction

    // Inputs change mid-cycle; outputs sampled 1ns after the edge.
    task automatic step(input logic r, input logic u,
                        input logic d);
        @(negedge clk);
        reset         = r;
        bus.unlock    = u;
        bus.door_open = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [10:0] got,
                         input logic [10:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got lr/al/busy/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     name, got[10], got[9], got[8], got[7:0],
                     exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    function automatic logic [10:0] outs();
        return {bus.latch_release, bus.door_alarm,
                bus.busy, bus.entry_count};
    endfunction

    task automatic entry();
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    int rel_cycles;
    int exp_cnt;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.unlock = 1'b0;
        bus.door_open = 1'b0;

        // reset and idle
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        // unlock, door never opens: 4 release cycles
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        // legitimate entry, door open 3 cycles
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        // door held ajar: alarm after 8 opened cycles
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 2));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 0, 1, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 2));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2));
        // door open and unlock edge together: forced alarm
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2));
        // reset mid-release, then unlock right after reset
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0));
        // edge during release ignored and not stored
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].unl, vecs[i].door);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].lr, vecs[i].al, vecs[i].bsy,
                   vecs[i].cnt});
        end

        // unlock held high 20 cycles: one release of 4 cycles
        rel_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0);
            if (bus.latch_release) rel_cycles++;
        end
        step(0, 0, 0);
        check("hold_unlock", 11'(rel_cycles), 11'd4);

        // reset during OPENED with five entries counted
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) entry();
        step(0, 1, 0);
        step(0, 0, 1);
        check("opened_cnt5", outs(), {3'b001, 8'd5});
        step(1, 0, 1);
        check("rst_opened", outs(), {3'b000, 8'd0});

        // reset during ALARM
        step(0, 0, 1);
        check("forced_alarm", outs(), {3'b011, 8'd0});
        step(1, 0, 1);
        check("rst_alarm", outs(), {3'b000, 8'd0});

        // saturation after 260 entries
        step(0, 0, 0);
        for (int i = 0; i < 260; i++) begin
            entry();
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            if (i >= 250)
                check($sformatf("sat%0d", i + 1), outs(),
                      {3'b000, 8'(exp_cnt)});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lock_ctrl.md
LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 Parameter OPEN_CYCLES, default 16, SHALL set the number of cycles the latch stays released while waiting for the door to open (legal range 2..1024).
REQ-002 Parameter AJAR_LIMIT, default 64, SHALL set the number of cycles the door may stay open before the alarm is raised (legal range 2..1024).
REQ-003 clk  input  1  SHALL be the clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 unlock  input  1  SHALL be the code-accepted level from the upstream sequence detector; only its rising edge SHALL be acted on.
REQ-006 door_open  input  1  SHALL be the door sensor (1 = door open), already synchronous to clk.
REQ-007 latch_release  output  1  SHALL drive the latch solenoid (1 = released).
REQ-008 door_alarm  output  1  SHALL flag a forced or ajar door.
REQ-009 busy  output  1  SHALL be 1 whenever the FSM is not in LOCKED.
REQ-010 entry_count  output  8  SHALL count completed legitimate entries.

Function
REQ-011 The block SHALL register unlock into unlock_q each cycle; unlock_edge SHALL be unlock & ~unlock_q.
REQ-012 The FSM SHALL have exactly the states LOCKED, RELEASE, OPENED, ALARM and RELOCK.
REQ-013 Outputs SHALL be Moore-decoded from the state only: latch_release = (state==RELEASE), door_alarm = (state==ALARM), busy = (state!=LOCKED).
REQ-014 In LOCKED, door_open=1 SHALL go to ALARM; else unlock_edge SHALL go to RELEASE; else the FSM SHALL stay in LOCKED; door_open SHALL win when both occur in the same cycle.
REQ-015 In RELEASE, a cycle counter cleared on entry SHALL increment each cycle; door_open=1 SHALL go to OPENED (priority over timeout); else count==OPEN_CYCLES-1 SHALL go to LOCKED, so latch_release is high for exactly OPEN_CYCLES cycles when the door never opens.
REQ-016 The RELEASE->OPENED transition SHALL increment entry_count by 1, saturating at 255.
REQ-017 In OPENED, an ajar counter cleared on entry SHALL increment each cycle; door_open=0 SHALL go to RELOCK; else count==AJAR_LIMIT-1 SHALL go to ALARM.
REQ-018 In ALARM, the FSM SHALL stay until door_open=0, then go to RELOCK.
REQ-019 RELOCK SHALL last exactly one cycle and then go to LOCKED unconditionally.
REQ-020 unlock_edge SHALL be ignored in every state other than LOCKED and SHALL NOT be stored for later.
REQ-021 A continuously high unlock SHALL produce only one RELEASE episode.
REQ-022 Counter widths SHALL be $clog2 of the respective parameter; the counters SHALL NOT wrap in legal operation.
REQ-023 Any unreachable state encoding SHALL go to LOCKED on the next cycle.

Reset
REQ-024 While reset=1 at a clk edge, the block SHALL set state=LOCKED, unlock_q=0, both counters=0 and entry_count=0, so latch_release=0, door_alarm=0 and busy=0 in the next cycle.
REQ-025 Reset SHALL take priority over every transition, including reset asserted mid-RELEASE, mid-OPENED or mid-ALARM.
REQ-026 If unlock=1 in the first cycle after reset deasserts, that cycle SHALL count as a rising edge.

Verification (OPEN_CYCLES=4, AJAR_LIMIT=8)
REQ-027 Unlock pulse with door_open=0 throughout -> latch_release=1 for exactly 4 cycles starting the cycle after the edge, then LOCKED, entry_count=0.
REQ-028 Unlock pulse, door_open=1 from the 2nd RELEASE cycle for 3 cycles, then door_open=0 -> OPENED for 3 cycles, busy=1 through one RELOCK cycle, then LOCKED, entry_count=1.
REQ-029 Unlock pulse, door held open -> door_alarm=1 after 8 OPENED cycles and held until door_open=0, then RELOCK, then LOCKED.
REQ-030 door_open=1 and unlock rising in the same LOCKED cycle -> ALARM next cycle with latch_release never asserted; unlock held high for 20 cycles yields one release only.
REQ-031 reset pulsed during OPENED with entry_count=5 -> next cycle: state LOCKED, all outputs 0, entry_count=0.
REQ-032 260 complete entries -> entry_count saturates at 255 and stays there.
